ysyx_23060124_ifu: RTL
======================

# ysyx_23060124_ifu

Instruction fetch unit for the ysyx_23060124 core. It sits directly upstream of the decode stage and owns the architectural fetch PC. It issues one AXI4-Lite read per instruction on the instruction bus and presents the fetched word, with its PC, to decode over a valid/ready handshake. It accepts PC redirects from branch, jump, trap, mret and fence.i resolution in later stages.

## Interface

Parameters:
- RESET_PC, 32'h3000_0000, PC fetched first after reset.

Ports:
- clock  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- o_araddr  output  32  read address; always equals the internal fetch PC.
- o_arvalid  output  1  read address valid.
- i_arready  input  1  read address accepted.
- i_rdata  input  32  read data.
- i_rresp  input  2  read response; any non-zero value is a fetch error.
- i_rvalid  input  1  read data valid.
- o_rready  output  1  read data ready.
- o_ins  output  32  instruction to decode; decode consumes bits 31:2.
- o_pc  output  32  PC of o_ins.
- o_fetch_err  output  1  o_ins comes from an error response or a misaligned PC.
- o_valid  output  1  o_ins, o_pc and o_fetch_err are valid.
- i_ready  input  1  decode accepts the current instruction.
- i_redirect  input  1  one-cycle pulse requesting a redirect.
- i_redirect_pc  input  32  redirect target; sampled only when i_redirect is 1.

## Operation

- The FSM has four states: ADDR, DATA, HOLD and ERR.
- ADDR
  - o_arvalid=1.
  - On i_arready, go to DATA.
  - If pc[1:0]!=0 on entry, go to ERR instead and issue no bus request.
- DATA
  - o_rready=1.
  - On i_rvalid, capture i_rdata into o_ins, set o_fetch_err = |i_rresp, then go to HOLD.
  - If pend_redir is set, discard the data, load pc from the pending target, clear pend_redir and go to ADDR.
- HOLD
  - o_valid=1.
  - On handshake (o_valid & i_ready), set pc <= pc+4 (mod 2^32) and go to ADDR.
- ERR
  - o_valid=1, o_ins=32'h0000_0013 (nop), o_fetch_err=1.
  - On handshake, set pc <= pc+4 and go to ADDR.
- Redirect rules:
  - In ADDR with o_arvalid=1, o_araddr must stay stable until i_arready.
    - The target is latched into pend_tgt and pend_redir is set.
    - The transaction completes and its data beat is discarded.
  - If i_redirect and i_arready occur in the same ADDR cycle, the redirect is latched as pending.
  - In DATA: latch the target as pending. If i_rvalid arrives in the same cycle, discard the beat and go to ADDR at the new target next cycle.
  - In HOLD or ERR: drop o_valid, set pc <= i_redirect_pc and go to ADDR next cycle.
    - If the handshake fires in the same cycle, the instruction counts as transferred.
    - The next pc is i_redirect_pc, not pc+4.
  - A new redirect while pend_redir is set overwrites pend_tgt; the last one wins.
- o_pc always equals pc. o_ins and o_fetch_err hold their values outside HOLD and ERR.
- At most one outstanding read; o_arvalid and o_rready are never high together.

## Timing

- Reset values:
  - state=ADDR, pc=RESET_PC, o_araddr=RESET_PC, o_pc=RESET_PC.
  - o_arvalid=0, o_rready=0, o_valid=0, o_fetch_err=0.
  - o_ins=32'h0000_0013, pend_redir=0.
- o_arvalid rises in the first cycle after reset deasserts.
- Best-case latency with zero-wait slave:
  - AR handshake in cycle 0, R beat in cycle 1, o_valid in cycle 2.
  - With i_ready=1: 3 cycles per instruction; the next o_arvalid appears in cycle 3.
- Redirect in HOLD at cycle t: o_valid=0 and o_araddr=target at t+1.
- Reset asserted mid-transaction:
  - All state returns to reset values in the next cycle.
  - A late R beat from the abandoned transaction is not accepted, because o_rready=0.
  - Slave-side cleanup of that transaction is the interconnect's responsibility.
- All outputs are registered or decoded from state only; there is no combinational input-to-output path.

## Test plan

- Reset release, zero-wait slave returning 32'h0010_0093 at 0x3000_0000:
  - o_araddr=0x3000_0000 at cycle 1.
  - o_valid at cycle 3 with o_ins=0x0010_0093 and o_pc=0x3000_0000.
  - Next o_araddr=0x3000_0004.
- Backpressure: hold i_ready=0 for 5 cycles in HOLD:
  - o_valid, o_ins and o_pc stay stable.
  - No new o_arvalid.
  - After i_ready=1, exactly one transfer occurs.
- i_redirect to 0x8000_0100 while o_arvalid=1 and i_arready=0 for 3 cycles:
  - o_araddr stays at the old pc.
  - The beat is discarded and o_valid never rises for it.
  - The next o_araddr is 0x8000_0100.
- Redirect in HOLD in the same cycle as the handshake (pc 0x3000_0010, target 0x3000_0040):
  - The transfer counts.
  - The next o_araddr is 0x3000_0040, not 0x3000_0014.
- i_rresp=2'b10 on a beat:
  - o_valid with o_fetch_err=1.
  - After the handshake, pc advances by 4.
- Redirect to 0x3000_0002:
  - No o_arvalid.
  - ERR presents o_ins=0x0000_0013, o_fetch_err=1, o_pc=0x3000_0002.
- pc=0xFFFF_FFFC handshake: next o_araddr=0x0000_0000.

Source files
------------

// File: rtl/ysyx_23060124_ifu.sv
// rtl/ysyx_23060124_ifu.sv - instruction fetch unit: one AXI4-Lite read per instruction, valid/ready to decode
module ysyx_23060124_ifu #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] o_araddr,
    output logic        o_arvalid,
    input  logic        i_arready,
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_rresp,
    input  logic        i_rvalid,
    output logic        o_rready,
    output logic [31:0] o_ins,
    output logic [31:0] o_pc,
    output logic        o_fetch_err,
    output logic        o_valid,
    input  logic        i_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ADDR,
        DATA,
        HOLD,
        ERR
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pend_tgt;
    logic        pend_redir;
    logic [31:0] pc_seq;

    assign pc_seq   = pc + 32'd4;
    assign o_araddr = pc;
    assign o_pc     = pc;

    // Fetch FSM; every path into ADDR pre-arms o_arvalid for an aligned pc so
    // back-to-back fetches cost three cycles, a misaligned pc waits one cycle
    // with o_arvalid low and then falls into ERR without touching the bus.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ADDR;
            pc          <= RESET_PC;
            pend_tgt    <= 32'h0;
            pend_redir  <= 1'b0;
            o_arvalid   <= 1'b0;
            o_rready    <= 1'b0;
            o_valid     <= 1'b0;
            o_fetch_err <= 1'b0;
            o_ins       <= NOP;
        end else begin
            case (state)
                ADDR: begin
                    if (!o_arvalid) begin
                        if (i_redirect) begin
                            pc        <= i_redirect_pc;
                            o_arvalid <= ~|i_redirect_pc[1:0];
                        end else if (|pc[1:0]) begin
                            state       <= ERR;
                            o_valid     <= 1'b1;
                            o_ins       <= NOP;
                            o_fetch_err <= 1'b1;
                        end else begin
                            o_arvalid <= 1'b1;
                        end
                    end else begin
                        // Address must stay stable while offered, so the
                        // redirect is parked until this transaction drains.
                        if (i_redirect) begin
                            pend_redir <= 1'b1;
                            pend_tgt   <= i_redirect_pc;
                        end
                        if (i_arready) begin
                            o_arvalid <= 1'b0;
                            o_rready  <= 1'b1;
                            state     <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (i_rvalid) begin
                        o_rready   <= 1'b0;
                        pend_redir <= 1'b0;
                        if (i_redirect) begin
                            pc        <= i_redirect_pc;
                            o_arvalid <= ~|i_redirect_pc[1:0];
                            state     <= ADDR;
                        end else if (pend_redir) begin
                            pc        <= pend_tgt;
                            o_arvalid <= ~|pend_tgt[1:0];
                            state     <= ADDR;
                        end else begin
                            o_ins       <= i_rdata;
                            o_fetch_err <= |i_rresp;
                            o_valid     <= 1'b1;
                            state       <= HOLD;
                        end
                    end else if (i_redirect) begin
                        pend_redir <= 1'b1;
                        pend_tgt   <= i_redirect_pc;
                    end
                end
                HOLD, ERR: begin
                    // A redirect overrides the sequential pc even when the
                    // handshake fires in the same cycle.
                    if (i_redirect) begin
                        o_valid   <= 1'b0;
                        pc        <= i_redirect_pc;
                        o_arvalid <= ~|i_redirect_pc[1:0];
                        state     <= ADDR;
                    end else if (i_ready) begin
                        o_valid   <= 1'b0;
                        pc        <= pc_seq;
                        o_arvalid <= ~|pc_seq[1:0];
                        state     <= ADDR;
                    end
                end
                default: begin
                    state <= ADDR;
                end
            endcase
        end
    end

endmodule
